// File: rtl/fir_tap_pipe.sv
// ============================================================================
//  Module   : fir_tap_pipe
//  Purpose  : Pipelined FIR tap engine with a runtime coefficient port,
//             valid tagging and an optional saturating output stage.
//             Define FIR_TAP_PIPE_SAT_EN to clamp the output and drive o_sat.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fir_tap_pipe #(
    parameter int TAPS  = 27,
    parameter int DW    = 4,
    parameter int CW    = 9,
    parameter int OW    = 16,
    parameter bit IN_SM = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_n,
    input  logic                    clr,
    input  logic                    i_vld,
    input  logic [DW-1:0]           i_data,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [CW-1:0]           coef_wdata,
    output logic                    o_vld,
    output logic [OW-1:0]           o_data,
    output logic                    o_sat
);

    localparam int c_LVL = $clog2(TAPS);
    localparam int c_LAT = c_LVL + 1;
    localparam int c_PW  = DW + CW;
    localparam int c_AW  = c_PW + c_LVL;

    // Number of operands at tree level l (level 0 = products).
    function automatic int lvl_cnt(input int l);
        return (TAPS + (1 << l) - 1) >> l;
    endfunction

    // Position of level l (l >= 1) inside the flattened tree node array.
    function automatic int lvl_off(input int l);
        int s;
        s = 0;
        for (int i = 1; i < l; i++) begin
            s += lvl_cnt(i);
        end
        return s;
    endfunction

    localparam int c_NODES = lvl_off(c_LVL + 1);

    logic signed [DW-1:0]    x_d;
    logic signed [DW-1:0]    x_q   [TAPS];
    logic signed [CW-1:0]    h_q   [TAPS];
    logic signed [c_PW-1:0]  w_prod [TAPS];
    logic signed [c_AW-1:0]  w_tree [c_NODES];
    logic [c_LAT-1:0]        vld_q;
    logic                    o_vld_q;
    logic [OW-1:0]           o_data_q;
    logic [OW-1:0]           o_data_d;

    generate
        if (IN_SM) begin : g_sm
            // Negating a zero magnitude yields zero, so -0 folds to 0.
            assign x_d = i_data[DW-1] ? -$signed({1'b0, i_data[DW-2:0]})
                                      :  $signed({1'b0, i_data[DW-2:0]});
        end else begin : g_tc
            assign x_d = $signed(i_data);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else if (!en_n) begin
            x_q[0] <= x_d;
            for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
        end
    end

    // Coefficient writes ignore both the stall and the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) h_q[k] <= '0;
        end else if (coef_we) begin
            for (int k = 0; k < TAPS; k++) begin
                if (int'(coef_addr) == k) h_q[k] <= coef_wdata;
            end
        end
    end

    generate
        for (genvar k = 0; k < TAPS; k++) begin : g_prod
            assign w_prod[k] = c_PW'(x_q[k]) * c_PW'(h_q[k]);
        end

        for (genvar l = 1; l <= c_LVL; l++) begin : g_lvl
            localparam int c_SRC = lvl_cnt(l - 1);
            for (genvar j = 0; j < lvl_cnt(l); j++) begin : g_node
                logic signed [c_AW-1:0] w_lhs;
                logic signed [c_AW-1:0] w_rhs;
                logic signed [c_AW-1:0] node_q;

                if (l == 1) begin : g_leaf
                    assign w_lhs = c_AW'(w_prod[2*j]);
                    if (2*j + 1 < c_SRC) begin : g_pair
                        assign w_rhs = c_AW'(w_prod[2*j+1]);
                    end else begin : g_odd
                        assign w_rhs = '0;
                    end
                end else begin : g_inner
                    assign w_lhs = w_tree[lvl_off(l-1) + 2*j];
                    if (2*j + 1 < c_SRC) begin : g_pair
                        assign w_rhs = w_tree[lvl_off(l-1) + 2*j + 1];
                    end else begin : g_odd
                        assign w_rhs = '0;
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        node_q <= '0;
                    end else if (clr) begin
                        node_q <= '0;
                    end else if (!en_n) begin
                        node_q <= w_lhs + w_rhs;
                    end
                end

                assign w_tree[lvl_off(l) + j] = node_q;
            end
        end
    endgenerate

`ifdef FIR_TAP_PIPE_SAT_EN
    logic sat_d;
    logic o_sat_q;
`endif

    generate
        if (c_AW > OW) begin : g_narrow
`ifdef FIR_TAP_PIPE_SAT_EN
            logic signed [c_AW-1:0] w_sum;
            logic                   w_ovf;
            assign w_sum = w_tree[c_NODES-1];
            // Fits in OW bits only when every bit above OW-2 matches the sign.
            assign w_ovf = !((&w_sum[c_AW-1:OW-1]) || !(|w_sum[c_AW-1:OW-1]));
            assign sat_d = w_ovf;
            assign o_data_d = !w_ovf        ? w_sum[OW-1:0] :
                              w_sum[c_AW-1] ? {1'b1, {(OW-1){1'b0}}} :
                                              {1'b0, {(OW-1){1'b1}}};
`else
            assign o_data_d = w_tree[c_NODES-1][OW-1:0];
`endif
        end else begin : g_wide
            assign o_data_d = OW'(w_tree[c_NODES-1]);
`ifdef FIR_TAP_PIPE_SAT_EN
            assign sat_d = 1'b0;
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            o_vld_q  <= 1'b0;
            o_data_q <= '0;
        end else if (clr) begin
            vld_q    <= '0;
            o_vld_q  <= 1'b0;
            o_data_q <= '0;
        end else if (!en_n) begin
            vld_q    <= {vld_q[c_LAT-2:0], i_vld};
            o_vld_q  <= vld_q[c_LAT-1];
            o_data_q <= o_data_d;
        end
    end

`ifdef FIR_TAP_PIPE_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sat_q <= 1'b0;
        end else if (clr) begin
            o_sat_q <= 1'b0;
        end else if (!en_n) begin
            o_sat_q <= sat_d;
        end
    end
    assign o_sat = o_sat_q;
`else
    assign o_sat = 1'b0;
`endif

    assign o_vld  = o_vld_q;
    assign o_data = o_data_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_tap_pipe.sv
// ============================================================================
//  Module   : tb_fir_tap_pipe
//  Purpose  : Self-checking bench for fir_tap_pipe (sign-magnitude and
//             two's-complement instances side by side).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fir_tap_pipe;

    localparam int c_TAPS = 27;
    localparam int c_LAT  = 6;

    typedef struct {
        bit     v;
        longint y;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en_n = 1'b1;
    logic        clr = 1'b0;
    logic        i_vld = 1'b0;
    logic [3:0]  i_data = '0;
    logic        coef_we = 1'b0;
    logic [4:0]  coef_addr = '0;
    logic [8:0]  coef_wdata = '0;
    logic        o_vld_sm, o_vld_tc;
    logic [15:0] o_data_sm, o_data_tc;
    logic        o_sat_sm, o_sat_tc;

    int total = 0;
    int bad = 0;

    longint hm [c_TAPS];
    longint xs_sm [$];
    longint xs_tc [$];
    ent_t   q_sm [$];
    ent_t   q_tc [$];
    logic [15:0] exp_d_sm, exp_d_tc;
    logic        exp_v_sm, exp_v_tc, exp_s_sm, exp_s_tc;

    always #5 clk = ~clk;

    fir_tap_pipe #(.TAPS(27), .DW(4), .CW(9), .OW(16), .IN_SM(1'b1)) dut_sm (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .clr(clr), .i_vld(i_vld),
        .i_data(i_data), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .o_vld(o_vld_sm), .o_data(o_data_sm), .o_sat(o_sat_sm)
    );

    fir_tap_pipe #(.TAPS(27), .DW(4), .CW(9), .OW(16), .IN_SM(1'b0)) dut_tc (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .clr(clr), .i_vld(i_vld),
        .i_data(i_data), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .o_vld(o_vld_tc), .o_data(o_data_tc), .o_sat(o_sat_tc)
    );

    // ---------------- reference model ----------------
    function automatic longint conv(input logic [3:0] d, input bit sm);
        longint m;
        if (sm) begin
            m = longint'(d[2:0]);
            return d[3] ? -m : m;
        end
        return longint'($signed(d));
    endfunction

    task automatic reduce(input longint y, output logic [15:0] od, output logic os);
`ifdef FIR_TAP_PIPE_SAT_EN
        if (y > 32767) begin
            od = 16'h7FFF; os = 1'b1;
        end else if (y < -32768) begin
            od = 16'h8000; os = 1'b1;
        end else begin
            od = y[15:0]; os = 1'b0;
        end
`else
        od = y[15:0];
        os = 1'b0;
`endif
    endtask

    task automatic model_flush();
        ent_t z;
        z.v = 1'b0;
        z.y = 0;
        xs_sm = {}; xs_tc = {}; q_sm = {}; q_tc = {};
        for (int k = 0; k < c_TAPS; k++) begin
            xs_sm.push_back(0);
            xs_tc.push_back(0);
        end
        for (int k = 0; k < c_LAT; k++) begin
            q_sm.push_back(z);
            q_tc.push_back(z);
        end
        exp_d_sm = '0; exp_d_tc = '0;
        exp_v_sm = 1'b0; exp_v_tc = 1'b0;
        exp_s_sm = 1'b0; exp_s_tc = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < c_TAPS; k++) hm[k] = 0;
        model_flush();
    endtask

    task automatic model_edge(input logic e_n, input logic cl, input logic v,
                              input logic [3:0] d, input logic we,
                              input logic [4:0] a, input logic [8:0] wd);
        longint y_sm;
        longint y_tc;
        ent_t   e;
        if (we && a < 5'd27) hm[a] = longint'($signed(wd));
        if (cl) begin
            model_flush();
        end else if (!e_n) begin
            void'(xs_sm.pop_back());
            void'(xs_tc.pop_back());
            xs_sm.push_front(conv(d, 1'b1));
            xs_tc.push_front(conv(d, 1'b0));
            y_sm = 0;
            y_tc = 0;
            for (int k = 0; k < c_TAPS; k++) begin
                y_sm += xs_sm[k] * hm[k];
                y_tc += xs_tc[k] * hm[k];
            end
            e.v = v; e.y = y_sm; q_sm.push_back(e);
            e.v = v; e.y = y_tc; q_tc.push_back(e);
            e = q_sm.pop_front();
            reduce(e.y, exp_d_sm, exp_s_sm);
            exp_v_sm = e.v;
            e = q_tc.pop_front();
            reduce(e.y, exp_d_tc, exp_s_tc);
            exp_v_tc = e.v;
        end
    endtask

    // ---------------- checking ----------------
    task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d (0x%h) expected=%0d (0x%h) t=%0t",
                   tag, $signed(got), got, $signed(expv), expv, $time);
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, "/sm_data"}, o_data_sm, exp_d_sm);
        cmp({tag, "/sm_vld"},  16'(o_vld_sm), 16'(exp_v_sm));
        cmp({tag, "/sm_sat"},  16'(o_sat_sm), 16'(exp_s_sm));
        cmp({tag, "/tc_data"}, o_data_tc, exp_d_tc);
        cmp({tag, "/tc_vld"},  16'(o_vld_tc), 16'(exp_v_tc));
        cmp({tag, "/tc_sat"},  16'(o_sat_tc), 16'(exp_s_tc));
    endtask

    task automatic cyc(input string tag, input logic e_n, input logic cl, input logic v,
                       input logic [3:0] d, input logic we, input logic [4:0] a,
                       input logic [8:0] wd);
        en_n = e_n; clr = cl; i_vld = v; i_data = d;
        coef_we = we; coef_addr = a; coef_wdata = wd;
        @(posedge clk);
        model_edge(e_n, cl, v, d, we, a, wd);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic run(input string tag, input logic e_n, input logic v, input logic [3:0] d);
        cyc(tag, e_n, 1'b0, v, d, 1'b0, 5'd0, 9'd0);
    endtask

    // mode 0: h[k]=k+1, mode 1: h[0]=5 others 0, mode 2: all 255
    task automatic load_coefs(input int mode);
        logic [8:0] w;
        for (int k = 0; k < c_TAPS; k++) begin
            w = (mode == 0) ? 9'(k + 1) : (mode == 1) ? ((k == 0) ? 9'd5 : 9'd0) : 9'd255;
            cyc("coef", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 5'(k), w);
        end
    endtask

    task automatic impulse_literal(input string tag);
        for (int c = 0; c <= 40; c++) begin
            run(tag, 1'b0, 1'b1, (c == 0) ? 4'd1 : 4'd0);
            cmp({tag, "/lit_data"}, o_data_sm, (c >= 6 && c <= 32) ? 16'(c - 5) : 16'd0);
            cmp({tag, "/lit_vld"},  16'(o_vld_sm), (c >= 6) ? 16'd1 : 16'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Impulse through h[k]=k+1; addresses >= 27 must be ignored.
        load_coefs(0);
        for (int a = 27; a < 32; a++) cyc("badaddr", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 5'(a), 9'h1FF);
        impulse_literal("impulse");

        // Impulse with a 3-cycle stall after output value 10.
        for (int c = 0; c <= 15; c++) begin
            run("stall_pre", 1'b0, 1'b1, (c == 0) ? 4'd1 : 4'd0);
            cmp("stall_pre/lit", o_data_sm, (c >= 6) ? 16'(c - 5) : 16'd0);
        end
        for (int s = 0; s < 3; s++) begin
            run("stall_hold", 1'b1, 1'($urandom), 4'($urandom));
            cmp("stall_hold/lit", o_data_sm, 16'd10);
        end
        for (int c = 16; c <= 35; c++) begin
            run("stall_post", 1'b0, 1'b1, 4'd0);
            cmp("stall_post/lit", o_data_sm, (c <= 32) ? 16'(c - 5) : 16'd0);
        end

        // Sign-magnitude versus two's-complement input.
        load_coefs(1);
        for (int c = 0; c <= 10; c++) begin
            run("sm", 1'b0, 1'b1, (c == 0) ? 4'b1011 : (c == 1) ? 4'b1000 : 4'b0000);
            if (c == 6) begin
                cmp("sm/neg3", o_data_sm, -16'sd15);
                cmp("tc/neg5", o_data_tc, -16'sd25);
            end
            if (c == 7) begin
                cmp("sm/negzero", o_data_sm, 16'd0);
                cmp("tc/neg8", o_data_tc, -16'sd40);
            end
        end

        // Mid-stream clear keeps coefficients; impulse must replay exactly.
        load_coefs(0);
        for (int c = 0; c < 10; c++) run("preclr", 1'b0, 1'($urandom), 4'($urandom));
        cyc("clr", 1'b0, 1'b1, 1'b1, 4'($urandom), 1'b1, 5'd31, 9'h1FF);
        cmp("clr/lit_data", o_data_sm, 16'd0);
        cmp("clr/lit_vld", 16'(o_vld_sm), 16'd0);
        impulse_literal("post_clr");

        // Saturation: positive then negative full-scale sums.
        load_coefs(2);
        for (int c = 0; c < 40; c++) run("sat_pos", 1'b0, 1'b1, 4'b0111);
`ifdef FIR_TAP_PIPE_SAT_EN
        cmp("sat_pos/lit_data", o_data_sm, 16'h7FFF);
        cmp("sat_pos/lit_sat", 16'(o_sat_sm), 16'd1);
`else
        cmp("sat_pos/lit_data", o_data_sm, -16'sd17341);
        cmp("sat_pos/lit_sat", 16'(o_sat_sm), 16'd0);
`endif
        for (int c = 0; c < 40; c++) run("sat_neg", 1'b0, 1'b1, 4'b1111);
`ifdef FIR_TAP_PIPE_SAT_EN
        cmp("sat_neg/lit_data", o_data_sm, 16'h8000);
        cmp("sat_neg/lit_sat", 16'(o_sat_sm), 16'd1);
`else
        cmp("sat_neg/lit_data", o_data_sm, 16'd17341);
        cmp("sat_neg/lit_sat", 16'(o_sat_sm), 16'd0);
`endif

        // Random traffic: stalls, clears and coefficient writes on enabled edges.
        for (int c = 0; c < 400; c++) begin
            logic e_n, cl, we;
            e_n = ($urandom_range(0, 3) == 0);
            cl  = ($urandom_range(0, 40) == 0);
            we  = !e_n && ($urandom_range(0, 2) == 0);
            cyc("random", e_n, cl, 1'($urandom), 4'($urandom), we,
                5'($urandom_range(0, 31)), 9'($urandom));
        end
        for (int c = 0; c < 10; c++) run("pre_rst", 1'b0, 1'b1, 4'b0111);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        cmp("arst/sm_data", o_data_sm, 16'd0);
        cmp("arst/sm_vld", 16'(o_vld_sm), 16'd0);
        cmp("arst/sm_sat", 16'(o_sat_sm), 16'd0);
        cmp("arst/tc_data", o_data_tc, 16'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_all("arst_rel");
        for (int c = 0; c < 20; c++) begin
            run("arst_imp", 1'b0, 1'(c % 3 != 1), (c == 0) ? 4'd1 : 4'($urandom));
            cmp("arst_imp/lit_data", o_data_sm, 16'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fir_tap_pipe.md
# fir_tap_pipe

Parametrised pipelined FIR filter: the next-generation tap engine for the sample path, generalised in tap count, sample width, coefficient width and output width. It adds a runtime coefficient write port, a valid tag that travels with each sample, a selectable sign-magnitude or two's-complement input, and optional output saturation. It sits between the sample source (magnitude/sign front end) and the downstream decimator or DAC formatter, and replaces fixed-size multiply/adder-tree instances.

## Interface
- `TAPS`, 27, number of filter taps (2..64)
- `DW`, 4, input sample width
- `CW`, 9, signed coefficient width
- `OW`, 16, output width
- `IN_SM`, 1, 1: `i_data` is sign-magnitude (MSB = sign); 0: two's complement
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `en_n`  in  1  active-low pipeline enable; high = stall
- `clr`  in  1  synchronous clear, active high
- `i_vld`  in  1  sample-valid tag
- `i_data`  in  DW  input sample
- `coef_we`  in  1  coefficient write strobe
- `coef_addr`  in  $clog2(TAPS)  tap index
- `coef_wdata`  in  CW  signed coefficient
- `o_vld`  out  1  output-valid tag
- `o_data`  out  OW  signed filter output
- `o_sat`  out  1  saturation flag for the current `o_data`

## Operation
- Input conversion: if `IN_SM`=1, the value is −mag when sign=1, else +mag. Sign-magnitude −0 maps to 0. If `IN_SM`=0, `i_data` is used as is.
- Delay line: `x[0..TAPS-1]`, each signed DW. On an enabled edge, `x[0]` takes the converted sample and `x[k]` takes `x[k-1]`. The line shifts on every enabled edge, whatever the value of `i_vld`. `i_vld` travels in a parallel shift register of depth LAT.
- Coefficients: `h[0..TAPS-1]`, signed CW, held in registers.
  - A write takes effect at the edge where `coef_we`=1, and it does so regardless of `en_n`.
  - A write with `coef_addr` ≥ TAPS is ignored.
  - `clr` does not affect the coefficients.
- Products: `p[k] = x[k]*h[k]`, combinational, full width DW+CW.
- Adder tree:
  - LVL = $clog2(TAPS) registered levels.
  - Each level sums adjacent pairs. An odd leftover element is registered through unchanged.
  - Internal width AW = DW+CW+LVL, sign-extended, so there is no internal overflow.
- Output: the final sum is reduced from AW to OW bits, either by saturation or by wrap (see Configuration).
- Priority per edge: `rst_n` low > `clr` > `en_n` high (hold) > normal update.
- Reset (async) clears all of the following: delay line, coefficients, tree registers, valid pipe, `o_data`=0, `o_vld`=0, `o_sat`=0.
- `clr` clears everything that reset clears except the coefficients, effective at the next edge.
- Stall (`en_n`=1): all data, tree, valid and output registers hold. `o_vld` and `o_data` stay at their last values. Downstream logic counts results only on enabled edges.
- A coefficient write in mid-stream takes effect in products on the cycle after the write edge. Results already in the tree mix old and new coefficients. This is accepted and no flush is performed.

## Timing
- Latency LAT = LVL+1 enabled edges. A sample captured at enabled edge E appears in `o_data`/`o_vld` at enabled edge E+LAT. For TAPS=27, LAT=6.
- Throughput: one sample per enabled cycle, with no bubbles.
- Stalled cycles add to latency one-for-one and cause no loss or duplication.
- `o_sat` is registered and aligned with `o_data`.

## Configuration
- `FIR_TAP_PIPE_SAT_EN` defined:
  - The final sum is clamped to [−2^(OW−1), 2^(OW−1)−1].
  - `o_sat`=1 for any clamped result.
- Not defined:
  - `o_data` = low OW bits of the sum (two's-complement wrap).
  - `o_sat` is tied to 0.
  - No comparator logic is built.

## Test plan
- Impulse: TAPS=27, h[k]=k+1, a single `i_data`=+1 followed by zeros, all with `i_vld`=1 → `o_data` = 1,2,…,27 starting 6 edges after capture, then 0. `o_vld` matches the `i_vld` pattern delayed by 6.
- Sign-magnitude: h[0]=5, all other taps 0.
  - `i_data`=4'b1011 → `o_data`=−15.
  - `i_data`=4'b1000 → `o_data`=0.
  - With `IN_SM`=0, 4'b1011 → −25.
- Stall: repeat the impulse with `en_n` high for 3 cycles after output sample 10 → `o_data` holds at 10 for 3 cycles. The sequence then continues 11…27 with no loss and no repeats.
- Clear/coef: `clr` pulse in mid-stream.
  - Next edge: `o_data`=0, `o_vld`=0, and the tree is empty.
  - The coefficients are retained, and a following impulse reproduces scenario 1 exactly.
  - `coef_addr`=31 writes are ignored.
- Saturation: all h=255, constant `i_data`=+7 for 27+ cycles → sum 48195.
  - With `FIR_TAP_PIPE_SAT_EN`: `o_data`=32767, `o_sat`=1.
  - Without: `o_data`=−17341, `o_sat`=0.
- Async reset: assert `rst_n` low between edges in mid-run → outputs go to 0 immediately. Afterwards all coefficients read back as 0: an impulse gives all-zero outputs with `o_vld` still tracking `i_vld`.
